// File: rtl/sr_latch_ctrl_if.sv
// Bundle between requesters, the shared-latch sequencer and the SR latch itself.
// The master side is the requesters plus the latch; the slave side is the sequencer.
interface sr_latch_ctrl_if #(
    parameter int N_REQ = 4
);
    logic [N_REQ-1:0] req_set;
    logic [N_REQ-1:0] req_clr;
    logic [N_REQ-1:0] grant;
    logic             busy;
    logic             done;
    logic             err;
    logic             latch_s;
    logic             latch_r;
    logic             latch_q;
    logic             latch_qbar;

    modport master (
        output req_set, req_clr, latch_q, latch_qbar,
        input  grant, busy, done, err, latch_s, latch_r
    );

    modport slave (
        input  req_set, req_clr, latch_q, latch_qbar,
        output grant, busy, done, err, latch_s, latch_r
    );
endinterface

// File: rtl/sr_latch_ctrl.sv
// Round-robin sequencer sharing one SR latch between N_REQ requesters: timed S/R pulse,
// settle window, Q/Qbar verification, done/err reporting. Includes a protocol checker.

module sr_latch_ctrl_chk #(
    parameter int N_REQ = 4
) (
    input logic             clk,
    input logic             rst,
    input logic [N_REQ-1:0] grant,
    input logic             done,
    input logic             err,
    input logic             latch_s,
    input logic             latch_r
);
    function automatic logic onehot0(input logic [N_REQ-1:0] v);
        return ((v & (v - N_REQ'(1))) == {N_REQ{1'b0}});
    endfunction

    // Protocol invariants on the sequencer outputs, sampled every edge outside reset.
    always @(posedge clk) begin
        if (!rst) begin
            a_no_sr_overlap: assert (!(latch_s && latch_r));
            a_grant_onehot0: assert (onehot0(grant));
            a_done_err_excl: assert (!(done && err));
        end
    end
endmodule

module sr_latch_ctrl #(
    parameter int N_REQ         = 4,
    parameter int PULSE_CYCLES  = 2,
    parameter int SETTLE_CYCLES = 1
) (
    input logic            clk,
    input logic            rst,
    sr_latch_ctrl_if.slave bus
);
    localparam int PTR_W   = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int MAX_CNT = (PULSE_CYCLES > SETTLE_CYCLES) ? PULSE_CYCLES : SETTLE_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CNT + 1);

    localparam logic [CNT_W-1:0] PULSE_LD  = CNT_W'(PULSE_CYCLES);
    localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(N_REQ - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_PULSE  = 3'd1,
        ST_SETTLE = 3'd2,
        ST_CHECK  = 3'd3,
        ST_FAULT  = 3'd4
    } state_t;

    state_t           state_r;
    logic [N_REQ-1:0] grant_r;
    logic             busy_r;
    logic             done_r;
    logic             err_r;
    logic             latch_s_r;
    logic             latch_r_r;
    logic             cmd_r;
    logic [CNT_W-1:0] cnt_r;
    logic [PTR_W-1:0] ptr_r;
    logic [PTR_W-1:0] win_r;

    logic [N_REQ-1:0] req_any_s;
    logic             found_s;
    logic [PTR_W-1:0] win_idx_s;
    logic             win_set_s;
    logic             win_clr_s;
    logic [N_REQ-1:0] win_onehot_s;
    logic             verify_ok_s;
    logic [PTR_W-1:0] ptr_next_s;

    assign req_any_s = bus.req_set | bus.req_clr;

    // Round-robin search starting at the pointer, wrapping modulo N_REQ.
    always_comb begin
        int idx_v;
        found_s   = 1'b0;
        win_idx_s = {PTR_W{1'b0}};
        idx_v     = 0;
        for (int k = 0; k < N_REQ; k++) begin
            idx_v = int'(ptr_r) + k;
            if (idx_v >= N_REQ) begin
                idx_v = idx_v - N_REQ;
            end else begin
                idx_v = idx_v;
            end
            if (!found_s && req_any_s[idx_v]) begin
                found_s   = 1'b1;
                win_idx_s = idx_v[PTR_W-1:0];
            end else begin
                found_s   = found_s;
            end
        end
    end

    // Decode of the winning requester's command and the post-operation pointer.
    always_comb begin
        win_set_s    = bus.req_set[win_idx_s];
        win_clr_s    = bus.req_clr[win_idx_s];
        win_onehot_s = N_REQ'(1) << win_idx_s;
        verify_ok_s  = (bus.latch_q == cmd_r) && (bus.latch_qbar == ~cmd_r);
        if (win_r == PTR_LAST) begin
            ptr_next_s = {PTR_W{1'b0}};
        end else begin
            ptr_next_s = win_r + PTR_W'(1);
        end
    end

    // Sequencer FSM; every output is a register so S/R never glitch.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            grant_r   <= {N_REQ{1'b0}};
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            err_r     <= 1'b0;
            latch_s_r <= 1'b0;
            latch_r_r <= 1'b0;
            cmd_r     <= 1'b0;
            cnt_r     <= {CNT_W{1'b0}};
            ptr_r     <= {PTR_W{1'b0}};
            win_r     <= {PTR_W{1'b0}};
        end else begin
            done_r <= 1'b0;
            err_r  <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (found_s) begin
                        grant_r <= win_onehot_s;
                        busy_r  <= 1'b1;
                        win_r   <= win_idx_s;
                        if (win_set_s && win_clr_s) begin
                            // Conflicting request: report without ever touching the latch.
                            state_r   <= ST_FAULT;
                            err_r     <= 1'b1;
                            latch_s_r <= 1'b0;
                            latch_r_r <= 1'b0;
                        end else begin
                            state_r   <= ST_PULSE;
                            cmd_r     <= win_set_s;
                            latch_s_r <= win_set_s;
                            latch_r_r <= ~win_set_s;
                            cnt_r     <= PULSE_LD;
                        end
                    end else begin
                        grant_r   <= {N_REQ{1'b0}};
                        busy_r    <= 1'b0;
                        latch_s_r <= 1'b0;
                        latch_r_r <= 1'b0;
                    end
                end
                ST_PULSE: begin
                    if (cnt_r == CNT_ONE) begin
                        state_r   <= ST_SETTLE;
                        latch_s_r <= 1'b0;
                        latch_r_r <= 1'b0;
                        cnt_r     <= SETTLE_LD;
                    end else begin
                        cnt_r <= cnt_r - CNT_ONE;
                    end
                end
                ST_SETTLE: begin
                    if (cnt_r == CNT_ONE) begin
                        // Feedback at the end of the settle window decides the CHECK-cycle result.
                        state_r <= ST_CHECK;
                        if (verify_ok_s) begin
                            done_r <= 1'b1;
                        end else begin
                            err_r <= 1'b1;
                        end
                    end else begin
                        cnt_r <= cnt_r - CNT_ONE;
                    end
                end
                ST_CHECK, ST_FAULT: begin
                    state_r   <= ST_IDLE;
                    grant_r   <= {N_REQ{1'b0}};
                    busy_r    <= 1'b0;
                    latch_s_r <= 1'b0;
                    latch_r_r <= 1'b0;
                    ptr_r     <= ptr_next_s;
                end
                default: begin
                    state_r   <= ST_IDLE;
                    grant_r   <= {N_REQ{1'b0}};
                    busy_r    <= 1'b0;
                    latch_s_r <= 1'b0;
                    latch_r_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.grant   = grant_r;
    assign bus.busy    = busy_r;
    assign bus.done    = done_r;
    assign bus.err     = err_r;
    assign bus.latch_s = latch_s_r;
    assign bus.latch_r = latch_r_r;

endmodule

// File: tb/tb_sr_latch_ctrl.sv
// Directed bench for sr_latch_ctrl with a clocked SR latch model as the shared resource.
module tb_sr_latch_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic q_model = 1'b0;
    logic stuck_q0 = 1'b0;
    logic mon_en = 1'b0;
    int   checks = 0;
    int   errors = 0;
    logic [8:0] obs;

    sr_latch_ctrl_if #(.N_REQ(4)) bus ();

    sr_latch_ctrl #(.N_REQ(4), .PULSE_CYCLES(2), .SETTLE_CYCLES(1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    sr_latch_ctrl_chk #(.N_REQ(4)) chk (
        .clk     (clk),
        .rst     (rst),
        .grant   (bus.grant),
        .done    (bus.done),
        .err     (bus.err),
        .latch_s (bus.latch_s),
        .latch_r (bus.latch_r)
    );

    always #5 clk = ~clk;

    // Shared SR latch: set wins on S, clears on R, holds otherwise.
    always @(posedge clk) begin
        if (bus.latch_s) q_model <= 1'b1;
        else if (bus.latch_r) q_model <= 1'b0;
    end

    assign bus.latch_q    = stuck_q0 ? 1'b0 : q_model;
    assign bus.latch_qbar = ~q_model;
    assign obs = {bus.grant, bus.busy, bus.latch_s, bus.latch_r, bus.done, bus.err};

    // Cycle-by-cycle invariants.
    always @(negedge clk) begin
        if (mon_en) begin
            checks++;
            if ((bus.latch_s & bus.latch_r) !== 1'b0 || (bus.done & bus.err) !== 1'b0 ||
                $countones(bus.grant) > 1) begin
                $display("FAIL invariant t=%0t s=%b r=%b done=%b err=%b grant=%b want no overlap, onehot0",
                         $time, bus.latch_s, bus.latch_r, bus.done, bus.err, bus.grant);
                errors++;
            end
        end
    end

    task automatic test_reset();
        rst = 1'b1;
        bus.req_set = 4'b0000;
        bus.req_clr = 4'b0000;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (obs !== 9'b0) begin
            $display("FAIL reset got %b want %b", obs, 9'b0);
            errors++;
        end
        rst = 1'b0;
        mon_en = 1'b1;
    endtask

    task automatic test_set_single();
        logic [8:0] exp;
        bus.req_set = 4'b0001;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            case (c)
                1, 2:    exp = 9'b0001_1_1_0_0_0;
                3:       exp = 9'b0001_1_0_0_0_0;
                4:       exp = 9'b0001_1_0_0_1_0;
                default: exp = 9'b0;
            endcase
            checks++;
            if (obs !== exp) begin
                $display("FAIL set_single c%0d got %b want %b", c, obs, exp);
                errors++;
            end
            if (c == 4) begin
                checks++;
                if ({bus.latch_q, bus.latch_qbar} !== 2'b10) begin
                    $display("FAIL set_single_q got %b want 10", {bus.latch_q, bus.latch_qbar});
                    errors++;
                end
                bus.req_set = 4'b0000;
            end
        end
    endtask

    task automatic test_clr_single();
        logic [8:0] exp;
        bus.req_clr = 4'b0100;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            case (c)
                1, 2:    exp = 9'b0100_1_0_1_0_0;
                3:       exp = 9'b0100_1_0_0_0_0;
                4:       exp = 9'b0100_1_0_0_1_0;
                default: exp = 9'b0;
            endcase
            checks++;
            if (obs !== exp) begin
                $display("FAIL clr_single c%0d got %b want %b", c, obs, exp);
                errors++;
            end
            if (c == 4) begin
                checks++;
                if ({bus.latch_q, bus.latch_qbar} !== 2'b01) begin
                    $display("FAIL clr_single_q got %b want 01", {bus.latch_q, bus.latch_qbar});
                    errors++;
                end
                bus.req_clr = 4'b0000;
            end
        end
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_g [5];
        int done_cnt;
        exp_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        done_cnt = 0;
        bus.req_set = 4'b1111;
        for (int c = 1; c <= 40 && done_cnt < 5; c++) begin
            @(negedge clk);
            if (bus.err) begin
                checks++;
                $display("FAIL rr_err c%0d got err=1 want 0", c);
                errors++;
            end
            if (bus.done) begin
                checks++;
                if (bus.grant !== exp_g[done_cnt] || c != 4 + 5 * done_cnt) begin
                    $display("FAIL rr_grant n%0d got %b at c%0d want %b at c%0d",
                             done_cnt, bus.grant, c, exp_g[done_cnt], 4 + 5 * done_cnt);
                    errors++;
                end
                done_cnt++;
                if (done_cnt == 5) bus.req_set = 4'b0000;
            end
        end
        checks++;
        if (done_cnt != 5) begin
            $display("FAIL rr_count got %0d want 5", done_cnt);
            errors++;
        end
        @(negedge clk);
        checks++;
        if (obs !== 9'b0) begin
            $display("FAIL rr_idle got %b want %b", obs, 9'b0);
            errors++;
        end
    endtask

    task automatic test_conflict();
        bus.req_set = 4'b0100;
        bus.req_clr = 4'b0100;
        @(negedge clk);
        checks++;
        if (obs !== 9'b0100_1_0_0_0_1) begin
            $display("FAIL conflict got %b want %b", obs, 9'b0100_1_0_0_0_1);
            errors++;
        end
        bus.req_set = 4'b0000;
        bus.req_clr = 4'b0000;
        @(negedge clk);
        checks++;
        if (obs !== 9'b0) begin
            $display("FAIL conflict_end got %b want %b", obs, 9'b0);
            errors++;
        end
    endtask

    task automatic test_verify_fault();
        logic [8:0] exp;
        stuck_q0 = 1'b1;
        bus.req_set = 4'b0001;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            case (c)
                1, 2:    exp = 9'b0001_1_1_0_0_0;
                3:       exp = 9'b0001_1_0_0_0_0;
                4:       exp = 9'b0001_1_0_0_0_1;
                default: exp = 9'b0;
            endcase
            checks++;
            if (obs !== exp) begin
                $display("FAIL verify_fault c%0d got %b want %b", c, obs, exp);
                errors++;
            end
            if (c == 4) bus.req_set = 4'b0000;
        end
        stuck_q0 = 1'b0;
        // Pointer moved past requester 0, so requester 1 must win over 0 now.
        bus.req_set = 4'b0011;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            case (c)
                1, 2:    exp = 9'b0010_1_1_0_0_0;
                3:       exp = 9'b0010_1_0_0_0_0;
                4:       exp = 9'b0010_1_0_0_1_0;
                default: exp = 9'b0;
            endcase
            checks++;
            if (obs !== exp) begin
                $display("FAIL ptr_advance c%0d got %b want %b", c, obs, exp);
                errors++;
            end
            if (c == 4) bus.req_set = 4'b0000;
        end
    endtask

    task automatic test_reset_mid_op();
        logic [8:0] exp;
        bus.req_set = 4'b0001;
        @(negedge clk);
        checks++;
        if (obs !== 9'b0001_1_1_0_0_0) begin
            $display("FAIL abort_start got %b want %b", obs, 9'b0001_1_1_0_0_0);
            errors++;
        end
        rst = 1'b1;
        bus.req_set = 4'b0000;
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            checks++;
            if (obs !== 9'b0) begin
                $display("FAIL abort_quiet c%0d got %b want %b", c, obs, 9'b0);
                errors++;
            end
            @(negedge clk);
        end
        bus.req_clr = 4'b0010;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            case (c)
                1, 2:    exp = 9'b0010_1_0_1_0_0;
                3:       exp = 9'b0010_1_0_0_0_0;
                4:       exp = 9'b0010_1_0_0_1_0;
                default: exp = 9'b0;
            endcase
            checks++;
            if (obs !== exp) begin
                $display("FAIL after_abort c%0d got %b want %b", c, obs, exp);
                errors++;
            end
            if (c == 4) begin
                checks++;
                if ({bus.latch_q, bus.latch_qbar} !== 2'b01) begin
                    $display("FAIL after_abort_q got %b want 01", {bus.latch_q, bus.latch_qbar});
                    errors++;
                end
                bus.req_clr = 4'b0000;
            end
        end
    endtask

    initial begin
        bus.req_set = 4'b0000;
        bus.req_clr = 4'b0000;
        test_reset();
        test_set_single();
        test_clr_single();
        test_reset();
        test_round_robin();
        test_conflict();
        test_verify_fault();
        test_reset_mid_op();
        mon_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
